// File: rtl/logic_unit_arbiter_if.sv
// Requester/consumer bundle for the shared logic unit: per-requester request,
// operand and opcode slices, the one-hot grant, and the result handshake.
interface logic_unit_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 6,
  parameter int IDW   = 2
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ*2-1:0]     opcode;
  logic [NREQ-1:0]       gnt;
  logic                  res_valid;
  logic                  res_ready;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;
  logic                  busy;

  modport master (
    output req, op_a, op_b, opcode, res_ready,
    input  gnt, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req, op_a, op_b, opcode, res_ready,
    output gnt, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// One registered AND/OR/mux unit shared round-robin among NREQ requesters;
// operands are captured at grant, executed for LAT cycles, returned via valid/ready.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 6,
  parameter int LAT   = 1,
  parameter int IDW   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  logic_unit_arbiter_if.slave  bus
);
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [1:0]       opc_q, opc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;

  logic [IDW-1:0]   win, win_lo, win_hi;
  logic             hi_found;
  logic [WIDTH-1:0] sel_a, sel_b;
  logic [1:0]       sel_op;

  function automatic logic [WIDTH-1:0] apply_op(input logic [1:0]       opc,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    case (opc)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      default: r = opc[0] ? b : a;
    endcase
    return r;
  endfunction

  // Winner: lowest set req at or above ptr, else lowest set req overall (wrap).
  always_comb begin
    win_lo   = '0;
    win_hi   = '0;
    hi_found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_lo = IDW'(i);
        if (i >= int'(ptr_q)) begin
          win_hi   = IDW'(i);
          hi_found = 1'b1;
        end
      end
    end
    win = hi_found ? win_hi : win_lo;

    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a  = bus.op_a[i*WIDTH +: WIDTH];
        sel_b  = bus.op_b[i*WIDTH +: WIDTH];
        sel_op = bus.opcode[2*i +: 2];
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first, so no path can infer a latch.
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    opc_d   = opc_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          owner_d = win;
          a_d     = sel_a;
          b_d     = sel_b;
          opc_d   = sel_op;
          gnt_d   = NREQ'(1) << win;
          cnt_d   = CW'(LAT - 1);
          ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          data_d  = apply_op(opc_q, a_q, b_q);
          id_d    = owner_q;
          valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.res_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      opc_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      opc_q   <= opc_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = valid_q;
  assign bus.res_data  = data_q;
  assign bus.res_id    = id_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one registered bitwise logic unit (AND/OR/2:1 mux, WIDTH bits) among NREQ requesters.
Round-robin arbitration, operand capture, and a multi-cycle execute sequenced by a down-counter.
Result is returned with the winner's ID over a valid/ready handshake.
Sits between the requesting controllers and the shared and2-bus / or / mux logic cells, in place of per-requester copies.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 6, operand/result width in bits
LAT, 1, execute cycles of the shared unit (1..8)
IDW, 2, requester ID width (>= clog2(NREQ))

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
req  input  NREQ  request per requester; held high until its gnt is seen
op_a  input  NREQ*WIDTH  operand A; slice i belongs to requester i
op_b  input  NREQ*WIDTH  operand B; slice i belongs to requester i
opcode  input  NREQ*2  per requester: 00 A&B, 01 A|B, 10 pass A, 11 pass B
gnt  output  NREQ  one-hot grant, registered, one-cycle pulse
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  result
res_id  output  IDW  index of the requester that owns res_data
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - State goes to IDLE; RR pointer goes to 0.
  - gnt=0, res_valid=0, res_data=0, res_id=0, busy=0, counter=0.
  - Reset mid-EXEC or mid-RESP drops the in-flight op; no res_valid is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req==0: stay in IDLE; pointer unchanged.
  - Else pick winner w = first set req bit searching from index ptr upward, wrapping at NREQ.
  - At the next edge:
    - capture op_a[w], op_b[w], opcode[w] and w;
    - gnt <= onehot(w);
    - counter <= LAT-1;
    - ptr <= (w+1) mod NREQ;
    - go to EXEC.
- EXEC:
  - gnt is high only in the first EXEC cycle; cleared at the next edge.
  - If counter != 0: decrement.
  - If counter == 0: res_data <= f(captured opcode, A, B), res_id <= w, res_valid <= 1, go to RESP.
  - Operands are captured at grant; input changes during EXEC/RESP have no effect.
- RESP:
  - res_valid, res_data, and res_id stay stable until res_ready=1 at an edge.
  - On that edge: res_valid <= 0, go to IDLE.
  - res_ready while res_valid=0 is ignored.
- Latency:
  - req sampled in IDLE at edge t: gnt high during cycle t..t+1.
  - res_valid rises at edge t+LAT.
  - Minimum spacing between grants is LAT+2 cycles (one IDLE cycle is always inserted).
- Simultaneous events:
  - A new req arriving during EXEC/RESP waits; it is arbitrated in the next IDLE cycle.
  - res_ready and a pending req in the same RESP cycle: the req is arbitrated in the following IDLE cycle.
- A requester whose req drops before gnt is simply skipped; there is no error.
- Fairness: with all req bits held high, grants go 0,1,2,...,NREQ-1,0,...
- Width rules:
  - Result is exactly WIDTH bits; no carry or extension.
  - Opcode 10/11 acts as a per-word mux, with opcode[0] as the select.

Test Plan:
1. Single requester, LAT=1: req=0001, op_a[0]=6'h2D, op_b[0]=6'h1B, opcode=00 → gnt=0001 for one cycle; res_valid 1 cycle later; res_data=6'h09, res_id=0; with res_ready=1, busy drops the next cycle.
2. Round robin: req=1111 held, res_ready=1 → grant order 0,1,2,3,0; each gnt is a one-cycle pulse; no two gnt bits ever set together.
3. Backpressure: req[2] with opcode=01, A=6'h30, B=6'h03, res_ready=0 for 5 cycles → res_valid=1 and res_data=6'h33 stay stable throughout; then res_ready=1 → res_valid=0 and state IDLE.
4. Mux opcodes, LAT=3: requester 1 opcode=10 (A=6'h15), then opcode=11 (B=6'h2A) → res_data=6'h15, then 6'h2A; res_valid rises exactly 3 cycles after each gnt pulse starts.
5. Reset mid-EXEC, LAT=4: assert rst on the 2nd EXEC cycle → next cycle all outputs are 0; ptr=0; no res_valid follows; next req=1010 grants requester 1.
6. Operand change after grant: modify op_a[3] the cycle after gnt[3] → res_data reflects the originally captured value.
